opacc_seq: RTL and testbench

Parametrised successor to the opacc/shift_fsm pair. It merges the outer-product accumulator datapath and its sequencer into one block. It holds NTILE independent C tiles of VL x ML elements and executes commands from the vector issue path: LOAD_C, MAC (K rank-1 updates, C += a*b^T), DRAIN_C and ZERO_C. Each data stream uses its own valid/ready handshake.

---
 rtl/opacc_seq.sv | 203 ++++++++++++++++++++
 tb/tb_opacc_seq.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/opacc_seq.sv
// opacc_seq: NTILE outer-product accumulator tiles (VL x ML) plus the LOAD/MAC/DRAIN/ZERO sequencer.
// Optional macro OPACC_SAT_EN: signed MAC with saturation; undefined gives wrap-around MAC.

module opacc_mac_lane #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] c,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] y
);
`ifdef OPACC_SAT_EN
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN:0]   sum;
    logic              ovf;

    // Sign-extended operands keep the low 2*XLEN bits of the signed product exact.
    assign prod = {{XLEN{a[XLEN-1]}}, a} * {{XLEN{b[XLEN-1]}}, b};
    assign sum  = {{(XLEN+1){c[XLEN-1]}}, c} + {prod[2*XLEN-1], prod};
    assign ovf  = !((&sum[2*XLEN:XLEN-1]) || !(|sum[2*XLEN:XLEN-1]));
    assign y    = !ovf ? sum[XLEN-1:0] :
                  sum[2*XLEN] ? {1'b1, {(XLEN-1){1'b0}}} : {1'b0, {(XLEN-1){1'b1}}};
`else
    assign y = c + a * b;
`endif
endmodule

module opacc_seq #(
    parameter int XLEN   = 64,
    parameter int VLEN   = 128,
    parameter int MLEN   = 128,
    parameter int NTILE  = 2,
    parameter int TILE_W = 1,
    parameter int KLEN_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [TILE_W-1:0] cmd_tile,
    input  logic [KLEN_W-1:0] cmd_len,
    input  logic              c_in_valid,
    output logic              c_in_ready,
    input  logic [VLEN-1:0]   vi_c,
    input  logic              ab_valid,
    output logic              ab_ready,
    input  logic [VLEN-1:0]   vi_a,
    input  logic [MLEN-1:0]   vi_b,
    output logic              c_out_valid,
    input  logic              c_out_ready,
    output logic [VLEN-1:0]   vo_c,
    output logic              busy,
    output logic              done
);
    localparam int VL    = VLEN / XLEN;
    localparam int ML    = MLEN / XLEN;
    localparam int COL_W = (ML > 1) ? $clog2(ML) : 1;
    localparam int CNT_W = (KLEN_W > COL_W + 1) ? KLEN_W : COL_W + 1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_DRAIN, S_ZERO} state_t;

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [TILE_W-1:0] tile_q;
    logic [KLEN_W-1:0] len_q;
    logic              done_d, cv_d, cmd_fire;
    logic              load_we, mac_we, zero_we, drain_ld;
    logic              tile_ok;
    logic [COL_W-1:0]  col, col_d;

    // Tiles are stored column-major so a LOAD/DRAIN beat is one packed VLEN column.
    logic [NTILE-1:0][ML-1:0][VLEN-1:0] tiles;
    logic [ML-1:0][VLEN-1:0]            cur, mac_res;

    assign tile_ok = (32'(tile_q) < NTILE);
    assign cur     = tiles[tile_ok ? tile_q : '0];
    assign col     = cnt[COL_W-1:0];
    assign col_d   = cnt_d[COL_W-1:0];

    for (genvar j = 0; j < ML; j++) begin : g_col
        for (genvar i = 0; i < VL; i++) begin : g_row
            opacc_mac_lane #(.XLEN(XLEN)) u_lane (
                .c (cur[j][i*XLEN +: XLEN]),
                .a (vi_a[i*XLEN +: XLEN]),
                .b (vi_b[j*XLEN +: XLEN]),
                .y (mac_res[j][i*XLEN +: XLEN])
            );
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            tile_q      <= '0;
            len_q       <= '0;
            done        <= 1'b0;
            c_out_valid <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            done        <= done_d;
            c_out_valid <= cv_d;
            if (cmd_fire) begin
                tile_q <= cmd_tile;
                len_q  <= cmd_len;
            end
        end
    end

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        done_d     = 1'b0;
        cv_d       = c_out_valid;
        cmd_fire   = 1'b0;
        load_we    = 1'b0;
        mac_we     = 1'b0;
        zero_we    = 1'b0;
        drain_ld   = 1'b0;
        cmd_ready  = (state == S_IDLE);
        c_in_ready = (state == S_LOAD);
        ab_ready   = (state == S_MAC);
        busy       = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    cmd_fire = 1'b1;
                    cnt_d    = '0;
                    case (cmd_op)
                        2'b00: state_d = S_LOAD;
                        2'b01: begin
                            // K = 0 completes straight from the accept cycle.
                            if (cmd_len == '0) done_d  = 1'b1;
                            else               state_d = S_MAC;
                        end
                        2'b10:   state_d = S_DRAIN;
                        default: state_d = S_ZERO;
                    endcase
                end
            end
            S_LOAD: begin
                if (c_in_valid) begin
                    load_we = 1'b1;
                    if (cnt == CNT_W'(ML - 1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt + 1'b1;
                    end
                end
            end
            S_MAC: begin
                if (ab_valid) begin
                    mac_we = 1'b1;
                    if ((cnt + 1'b1) == CNT_W'(len_q)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (!c_out_valid) begin
                    drain_ld = 1'b1;
                    cv_d     = 1'b1;
                end else if (c_out_ready) begin
                    if (cnt == CNT_W'(ML - 1)) begin
                        cv_d    = 1'b0;
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d    = cnt + 1'b1;
                        drain_ld = 1'b1;
                    end
                end
            end
            S_ZERO: begin
                zero_we = 1'b1;
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tiles <= '0;
            vo_c  <= '0;
        end else begin
            if (tile_ok) begin
                if (load_we) tiles[tile_q][col] <= vi_c;
                if (mac_we)  tiles[tile_q]      <= mac_res;
                if (zero_we) tiles[tile_q]      <= '0;
            end
            // Out-of-range tiles drain zeros; the column shown is the one about to be offered.
            if (drain_ld) vo_c <= tile_ok ? cur[col_d] : '0;
        end
    end
endmodule

// File: tb/tb_opacc_seq.sv
// Scoreboard bench for opacc_seq: drain beats are checked against a queue filled from a tile model.
module tb_opacc_seq;
    localparam int XLEN = 64, VLEN = 128, MLEN = 128, NTILE = 2, TILE_W = 1, KLEN_W = 8;
    localparam int VL = VLEN / XLEN, ML = MLEN / XLEN;
    localparam logic [1:0] OP_LOAD = 2'b00, OP_MAC = 2'b01, OP_DRAIN = 2'b10, OP_ZERO = 2'b11;

    logic              clk, reset_n;
    logic              cmd_valid, cmd_ready;
    logic [1:0]        cmd_op;
    logic [TILE_W-1:0] cmd_tile;
    logic [KLEN_W-1:0] cmd_len;
    logic              c_in_valid, c_in_ready;
    logic [VLEN-1:0]   vi_c, vi_a;
    logic              ab_valid, ab_ready;
    logic [MLEN-1:0]   vi_b;
    logic              c_out_valid, c_out_ready;
    logic [VLEN-1:0]   vo_c;
    logic              busy, done;

    opacc_seq #(.XLEN(XLEN), .VLEN(VLEN), .MLEN(MLEN), .NTILE(NTILE), .TILE_W(TILE_W),
                .KLEN_W(KLEN_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_tile(cmd_tile), .cmd_len(cmd_len),
        .c_in_valid(c_in_valid), .c_in_ready(c_in_ready), .vi_c(vi_c),
        .ab_valid(ab_valid), .ab_ready(ab_ready), .vi_a(vi_a), .vi_b(vi_b),
        .c_out_valid(c_out_valid), .c_out_ready(c_out_ready), .vo_c(vo_c),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0, errors = 0, done_cnt = 0, exp_done = 0;
    logic [VLEN-1:0] exp_q[$];
    logic [VLEN-1:0] mt[NTILE][ML];

    task automatic chk(input string tag, input logic [VLEN-1:0] got, input logic [VLEN-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    always @(negedge clk) begin
        if (reset_n && done) done_cnt++;
        if (reset_n && c_out_valid && c_out_ready) begin
            if (exp_q.size() == 0) chk("drain_extra", VLEN'(1), VLEN'(0));
            else                   chk("drain_beat", vo_c, exp_q.pop_front());
        end
    end

    task automatic do_cmd(input logic [1:0] op, input int tile, input int len);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 200) begin tick(); n++; end
        if (n >= 200) chk("cmd_timeout", VLEN'(cmd_ready), VLEN'(1));
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_tile  = TILE_W'(tile);
        cmd_len   = KLEN_W'(len);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 200) begin tick(); n++; end
        chk(tag, VLEN'(done), VLEN'(1));
        exp_done++;
    endtask

    task automatic step_end(input string tag);
        tick();
        chk(tag, VLEN'(done_cnt), VLEN'(exp_done));
    endtask

    task automatic load_tile(input int t, input logic [VLEN-1:0] c0, input logic [VLEN-1:0] c1);
        do_cmd(OP_LOAD, t, 0);
        chk("load_ready", VLEN'({c_in_ready, busy}), VLEN'(2'b11));
        c_in_valid = 1'b1; vi_c = c0; tick();
        c_in_valid = 1'b0; vi_c = '1; tick();     // idle gap: beat must be ignored
        c_in_valid = 1'b1; vi_c = c1; tick();
        c_in_valid = 1'b0;
        mt[t][0] = c0;
        mt[t][1] = c1;
        wait_done("load_done");
    endtask

    task automatic mac_beat(input int t, input logic [VLEN-1:0] a, input logic [MLEN-1:0] b);
        logic [XLEN-1:0] e, ai, bj;
        ab_valid = 1'b1; vi_a = a; vi_b = b;
        tick();
        ab_valid = 1'b0;
        for (int i = 0; i < VL; i++)
            for (int j = 0; j < ML; j++) begin
                e  = mt[t][j][i*XLEN +: XLEN];
                ai = a[i*XLEN +: XLEN];
                bj = b[j*XLEN +: XLEN];
`ifdef OPACC_SAT_EN
                begin
                    logic signed [2*XLEN+1:0] s;
                    s = $signed({{(XLEN+2){e[XLEN-1]}}, e}) +
                        $signed({{(XLEN+2){ai[XLEN-1]}}, ai}) * $signed({{(XLEN+2){bj[XLEN-1]}}, bj});
                    if (s > $signed({{(XLEN+3){1'b0}}, {(XLEN-1){1'b1}}}))
                        e = {1'b0, {(XLEN-1){1'b1}}};
                    else if (s < $signed({{(XLEN+3){1'b1}}, {(XLEN-1){1'b0}}}))
                        e = {1'b1, {(XLEN-1){1'b0}}};
                    else
                        e = s[XLEN-1:0];
                end
`else
                e = e + ai * bj;
`endif
                mt[t][j][i*XLEN +: XLEN] = e;
            end
    endtask

    task automatic drain_tile(input int t);
        for (int j = 0; j < ML; j++) exp_q.push_back(mt[t][j]);
        do_cmd(OP_DRAIN, t, 0);
        c_out_ready = 1'b1;
        wait_done("drain_done");
        c_out_ready = 1'b0;
        chk("drain_left", VLEN'(exp_q.size()), VLEN'(0));
    endtask

    initial begin
        logic [VLEN-1:0] held;
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_tile = '0; cmd_len = '0;
        c_in_valid = 1'b0; vi_c = '0; ab_valid = 1'b0; vi_a = '0; vi_b = '0; c_out_ready = 1'b0;
        for (int t = 0; t < NTILE; t++) for (int j = 0; j < ML; j++) mt[t][j] = '0;
        #3;
        chk("rst_cmd_ready", VLEN'(cmd_ready), VLEN'(1));
        chk("rst_flags", VLEN'({busy, done, c_out_valid, c_in_ready, ab_ready}), VLEN'(0));
        chk("rst_vo_c", vo_c, '0);
        @(posedge clk); #2;
        reset_n = 1'b1;
        tick();

        // load / drain round trip
        load_tile(0, {64'd10, 64'd0}, {64'd11, 64'd1});
        drain_tile(0);
        step_end("done_cnt_load_drain");

        // zero then rank-1 updates with a_k = {k, k+1}, b_k = {1, 2}
        do_cmd(OP_ZERO, 0, 0);
        for (int j = 0; j < ML; j++) mt[0][j] = '0;
        wait_done("zero_done");
        do_cmd(OP_MAC, 0, 3);
        for (int k = 0; k < 3; k++) mac_beat(0, {64'(k + 1), 64'(k)}, {64'd2, 64'd1});
        wait_done("mac_done");
        drain_tile(0);
        step_end("done_cnt_mac");

        // tile isolation
        load_tile(1, {64'd5, 64'd5}, {64'd5, 64'd5});
        do_cmd(OP_MAC, 0, 2);
        for (int k = 0; k < 2; k++)
            mac_beat(0, {64'($urandom_range(255)), 64'($urandom_range(255))},
                        {64'($urandom_range(255)), 64'($urandom_range(255))});
        wait_done("mac2_done");
        drain_tile(1);
        drain_tile(0);
        step_end("done_cnt_iso");

        // back-pressure on beat 0
        for (int j = 0; j < ML; j++) exp_q.push_back(mt[0][j]);
        do_cmd(OP_DRAIN, 0, 0);
        begin
            int n = 0;
            while (c_out_valid !== 1'b1 && n < 20) begin tick(); n++; end
        end
        held = vo_c;
        for (int s = 0; s < 3; s++) begin
            tick();
            chk("stall_valid", VLEN'(c_out_valid), VLEN'(1));
            chk("stall_data", vo_c, held);
        end
        c_out_ready = 1'b1;
        wait_done("stall_done");
        c_out_ready = 1'b0;
        chk("stall_beats", VLEN'(exp_q.size()), VLEN'(0));
        step_end("done_cnt_stall");

        // K = 0 completes without a beat
        do_cmd(OP_MAC, 0, 0);
        chk("k0_ab_ready", VLEN'(ab_ready), VLEN'(0));
        chk("k0_done", VLEN'({done, cmd_ready, busy}), VLEN'(3'b110));
        exp_done++;
        step_end("done_cnt_k0");

        // reset in the middle of a MAC
        do_cmd(OP_MAC, 0, 4);
        mac_beat(0, {64'd3, 64'd4}, {64'd5, 64'd6});
        ab_valid = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        chk("abort_flags", VLEN'({busy, done, ab_ready, cmd_ready}), VLEN'(4'b0001));
        ab_valid = 1'b0;
        tick(); tick();
        chk("abort_no_done", VLEN'(done), VLEN'(0));
        reset_n = 1'b1;
        for (int t = 0; t < NTILE; t++) for (int j = 0; j < ML; j++) mt[t][j] = '0;
        tick();
        drain_tile(0);
        drain_tile(1);
        step_end("done_cnt_abort");

        // wrap vs saturate on C00
`ifdef OPACC_SAT_EN
        load_tile(0, {64'd0, 64'h7FFF_FFFF_FFFF_FFFF}, '0);
`else
        load_tile(0, {64'd0, 64'hFFFF_FFFF_FFFF_FFFF}, '0);
`endif
        do_cmd(OP_MAC, 0, 1);
        mac_beat(0, {64'd0, 64'd1}, {64'd0, 64'd1});
        wait_done("edge_mac_done");
        drain_tile(0);
        step_end("done_cnt_edge");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
